// File: rtl/popcount_seq_ctrl.sv
// Sequencing controller: streams a wide word one nibble per cycle through an
// external 4-bit ones-counter and accumulates the returned counts.
module popcount_seq_ctrl #(
  parameter int NIBBLES = 4,
  parameter int CNT_W   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [4*NIBBLES-1:0] data_in,
  input  logic                 abort,
  output logic [3:0]           nib_out,
  input  logic [2:0]           nib_cnt_in,
  output logic [CNT_W-1:0]     cnt_out,
  output logic                 cnt_valid,
  input  logic                 cnt_ready,
  output logic                 busy,
  output logic                 err
);

  localparam int IDX_W = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [4*NIBBLES-1:0]   r_shift;
  logic [CNT_W-1:0]       r_acc;
  logic [CNT_W-1:0]       r_cnt_out;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_err;

  logic                   w_accept;
  logic                   w_last;
  logic [CNT_W-1:0]       w_sum;

  assign w_accept = (r_state == S_IDLE) && start_valid && !abort;
  assign w_last   = (r_idx == IDX_W'(NIBBLES - 1));
  assign w_sum    = r_acc + CNT_W'(nib_cnt_in);

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start_valid) w_next = S_RUN;
        S_RUN:   if (w_last)      w_next = S_DONE;
        S_DONE:  if (cnt_ready)   w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift   <= '0;
      r_acc     <= '0;
      r_cnt_out <= '0;
      r_idx     <= '0;
      r_err     <= 1'b0;
    end else if (abort) begin
      r_acc     <= '0;
      r_cnt_out <= '0;
    end else if (w_accept) begin
      r_shift   <= data_in;
      r_acc     <= '0;
      r_cnt_out <= '0;
      r_idx     <= '0;
      r_err     <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_acc   <= w_sum;
      r_shift <= r_shift >> 4;
      r_idx   <= r_idx + 1'b1;
      if (nib_cnt_in > 3'd4) r_err <= 1'b1;
      // Result register is loaded on the final add so it is stable throughout DONE.
      if (w_last) r_cnt_out <= w_sum;
    end
  end

  assign start_ready = (r_state == S_IDLE);
  assign busy        = (r_state == S_RUN) || (r_state == S_DONE);
  assign cnt_valid   = (r_state == S_DONE);
  assign nib_out     = (r_state == S_RUN) ? r_shift[3:0] : 4'd0;
  assign cnt_out     = r_cnt_out;
  assign err         = r_err;

endmodule

// File: tb/tb_popcount_seq_ctrl.sv
// Directed self-checking bench for popcount_seq_ctrl (NIBBLES=4, CNT_W=5).
module tb_popcount_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] data_in;
  logic        abort;
  logic [3:0]  nib_out;
  logic [2:0]  nib_cnt_in;
  logic [4:0]  cnt_out;
  logic        cnt_valid;
  logic        cnt_ready;
  logic        busy;
  logic        err;
  logic        inject;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // External 4-bit ones-counter model, with a fault injector returning 7.
  assign nib_cnt_in = inject ? 3'd7 : 3'($countones(nib_out));

  popcount_seq_ctrl #(.NIBBLES(4), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready), .data_in(data_in),
    .abort(abort), .nib_out(nib_out), .nib_cnt_in(nib_cnt_in),
    .cnt_out(cnt_out), .cnt_valid(cnt_valid), .cnt_ready(cnt_ready),
    .busy(busy), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Accept a word, check each RUN cycle's nibble, then DONE with optional back-pressure.
  task automatic run_word(input logic [15:0] d, input logic [4:0] exp, input int hold, input string tag);
    start_valid = 1'b1;
    data_in     = d;
    step();
    start_valid = 1'b0;
    check({tag, "_cnt_cleared"}, cnt_out, 5'd0);
    for (int j = 0; j < 4; j++) begin
      check({tag, "_nib"}, nib_out, (d >> (4 * j)) & 16'hF);
      check({tag, "_busy_run"}, busy, 1'b1);
      check({tag, "_valid_low"}, cnt_valid, 1'b0);
      step();
    end
    check({tag, "_valid"}, cnt_valid, 1'b1);
    check({tag, "_cnt"}, cnt_out, exp);
    for (int h = 0; h < hold; h++) begin
      step();
      check({tag, "_hold_valid"}, cnt_valid, 1'b1);
      check({tag, "_hold_cnt"}, cnt_out, exp);
      check({tag, "_hold_busy"}, busy, 1'b1);
    end
    cnt_ready = 1'b1;
    step();
    cnt_ready = 1'b0;
    check({tag, "_idle_ready"}, start_ready, 1'b1);
    check({tag, "_idle_valid"}, cnt_valid, 1'b0);
    check({tag, "_idle_busy"}, busy, 1'b0);
    check({tag, "_cnt_kept"}, cnt_out, exp);
  endtask

  initial begin
    rst = 1'b1; start_valid = 1'b0; data_in = '0; abort = 1'b0;
    cnt_ready = 1'b0; inject = 1'b0;
    step();
    check("rst_ready", start_ready, 1'b1);
    check("rst_valid", cnt_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cnt", cnt_out, 5'd0);
    check("rst_nib", nib_out, 4'd0);
    check("rst_err", err, 1'b0);
    rst = 1'b0;
    step();

    run_word(16'hFFFF, 5'd16, 0, "ffff");
    run_word(16'h0000, 5'd0, 0, "zero");
    run_word(16'h1234, 5'd5, 0, "h1234");
    run_word(16'hA5C3, 5'd8, 3, "a5c3");

    // Requests during RUN and during the DONE/cnt_ready cycle are ignored.
    start_valid = 1'b1; data_in = 16'h1111;
    step();
    data_in = 16'h00FF;
    check("ign_nib0", nib_out, 4'h1);
    for (int j = 0; j < 4; j++) step();
    check("ign_first_cnt", cnt_out, 5'd4);
    check("ign_ready_done", start_ready, 1'b0);
    cnt_ready = 1'b1;
    step();
    cnt_ready = 1'b0;
    check("ign_idle", start_ready, 1'b1);
    check("ign_cnt_kept", cnt_out, 5'd4);
    step();
    start_valid = 1'b0;
    check("ign_accept_busy", busy, 1'b1);
    check("ign_accept_nib", nib_out, 4'hF);
    for (int j = 0; j < 4; j++) step();
    check("ign_result", cnt_out, 5'd8);
    check("ign_result_valid", cnt_valid, 1'b1);
    cnt_ready = 1'b1;
    step();
    cnt_ready = 1'b0;

    // Abort in the second RUN cycle, with a competing start_valid.
    start_valid = 1'b1; data_in = 16'hFFFF;
    step();
    start_valid = 1'b0;
    step();
    check("abt_in_run", busy, 1'b1);
    abort = 1'b1; start_valid = 1'b1;
    step();
    abort = 1'b0; start_valid = 1'b0;
    check("abt_idle", start_ready, 1'b1);
    check("abt_busy", busy, 1'b0);
    check("abt_cnt", cnt_out, 5'd0);
    check("abt_nib", nib_out, 4'd0);
    for (int j = 0; j < 5; j++) begin
      step();
      check("abt_valid_low", cnt_valid, 1'b0);
      check("abt_stay_idle", busy, 1'b0);
    end

    // Faulty counter output on the second nibble sets sticky err.
    start_valid = 1'b1; data_in = 16'hFFFF;
    step();
    start_valid = 1'b0;
    check("err_start", err, 1'b0);
    step();
    inject = 1'b1;
    check("err_before", err, 1'b0);
    step();
    inject = 1'b0;
    check("err_set", err, 1'b1);
    step(); step();
    check("err_done_valid", cnt_valid, 1'b1);
    check("err_done_err", err, 1'b1);
    check("err_done_cnt", cnt_out, 5'd19);
    cnt_ready = 1'b1;
    step();
    cnt_ready = 1'b0;
    check("err_idle_kept", err, 1'b1);
    start_valid = 1'b1; data_in = 16'h0F00;
    step();
    start_valid = 1'b0;
    check("err_cleared", err, 1'b0);
    for (int j = 0; j < 4; j++) step();
    check("err_next_cnt", cnt_out, 5'd4);

    // Async reset while in DONE with err set, away from any clock edge.
    inject = 1'b1;
    cnt_ready = 1'b1;
    step();
    cnt_ready = 1'b0;
    start_valid = 1'b1; data_in = 16'h0001;
    step();
    start_valid = 1'b0;
    for (int j = 0; j < 4; j++) step();
    inject = 1'b0;
    check("ar_pre_valid", cnt_valid, 1'b1);
    check("ar_pre_err", err, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", cnt_valid, 1'b0);
    check("ar_busy", busy, 1'b0);
    check("ar_ready", start_ready, 1'b1);
    check("ar_cnt", cnt_out, 5'd0);
    check("ar_err", err, 1'b0);
    check("ar_nib", nib_out, 4'd0);
    step();
    rst = 1'b0;
    step();
    run_word(16'h8421, 5'd4, 1, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/popcount_seq_ctrl.md
Name: popcount_seq_ctrl

Overview:
Sequencing controller that computes the ones-count of a wide word by streaming it, one nibble per cycle, through a single shared 4-bit ones-counter datapath.
- Accepts a word over a valid/ready handshake.
- Drives nibbles out to the external 4-bit counter and accumulates the returned 3-bit counts.
- Presents the total over a second valid/ready handshake.
- Sits between the requesting logic and the 4-bit ones-counter, so wide popcounts reuse one small combinational counter instead of replicating it.

Parameters:
NIBBLES, 4, number of 4-bit nibbles per input word; word width = 4*NIBBLES; legal range 2..16.
CNT_W, 5, accumulator/result width; must satisfy 2^CNT_W > 4*NIBBLES (5 for NIBBLES=4).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start_valid  input  1  requester has a word on data_in.
start_ready  output  1  controller can accept a word (IDLE only).
data_in  input  4*NIBBLES  word to be counted; sampled only on accept.
abort  input  1  synchronous cancel; returns the controller to IDLE.
nib_out  output  4  nibble driven to the external 4-bit ones-counter.
nib_cnt_in  input  3  ones-count returned combinationally by the external counter for nib_out.
cnt_out  output  CNT_W  total ones-count; stable while cnt_valid=1.
cnt_valid  output  1  result available.
cnt_ready  input  1  consumer takes the result.
busy  output  1  high in RUN or DONE.
err  output  1  sticky: nib_cnt_in>4 was seen during RUN.

Behaviour:
- Reset (async, rst=1): state=IDLE; shift register, accumulator, index, cnt_out and err=0; nib_out=0; cnt_valid=0; busy=0; start_ready=1 (state-decoded). No transaction survives reset, and a reset mid-RUN or mid-DONE discards the work.
- States: IDLE, RUN, DONE. Registered state, with outputs decoded from the state.
- IDLE:
  - start_ready=1, nib_out=0.
  - On start_valid & start_ready at a clock edge: latch data_in into the shift register, clear the accumulator, set index=0, clear err, go to RUN.
- RUN:
  - nib_out = shift register bits [3:0], least significant nibble first.
  - Each edge: accumulator += zero-extended nib_cnt_in; shift register >>= 4 (zero fill); index++.
  - If nib_cnt_in>4, set err (sticky).
  - When index reaches NIBBLES-1, the same edge performs the final add and moves to DONE.
  - Exactly NIBBLES RUN cycles per word.
- DONE:
  - cnt_valid=1, cnt_out=accumulator, held constant.
  - On cnt_ready=1 at an edge: go to IDLE; cnt_valid drops on the next cycle.
  - Back-pressure of any length is legal; nothing changes while cnt_ready=0.
- Latency:
  - Acceptance at edge k gives cnt_valid=1 from edge k+NIBBLES.
  - With cnt_ready tied high, throughput is one word per NIBBLES+2 cycles.
- start_ready=0 in RUN and DONE. start_valid there is ignored and no data is captured, including when start_valid coincides with cnt_ready in DONE. The requester holds its request until IDLE.
- abort:
  - Synchronous, highest priority after rst.
  - In any state: next state IDLE, cnt_valid=0, accumulator and cnt_out cleared, nib_out=0.
  - abort with start_valid in IDLE: abort wins and nothing is accepted.
- Arithmetic: the accumulator never exceeds 4*NIBBLES and cannot wrap given the CNT_W rule. With err set, the result is undefined but no overflow checking is required.
- cnt_out holds its last value after returning to IDLE until the next accept clears it.

Test Plan:
- Basic count: NIBBLES=4, accept 16'hFFFF, nib_cnt_in driven by a correct 4-bit ones-counter model -> cnt_valid rises 4 edges after accept; cnt_out=16; busy=1 from accept until cnt_ready.
- Zero and nibble ordering: accept 16'h0000 -> cnt_out=0. Then accept 16'h1234 -> nib_out sequence 4,3,2,1 in RUN; cnt_out=5.
- Mixed pattern with back-pressure: accept 16'hA5C3, hold cnt_ready=0 for 3 cycles -> cnt_out=8 stable and cnt_valid=1 throughout. Then cnt_ready=1 -> IDLE next cycle with start_ready=1.
- Ignored request: start_valid=1 with data 16'h00FF asserted during RUN and during the DONE/cnt_ready cycle -> no capture; accepted only in the following IDLE cycle; result=8.
- Abort and reset mid-operation: abort in the 2nd RUN cycle -> IDLE, cnt_valid stays 0, cnt_out=0. Async rst in DONE -> all outputs at reset values immediately, without a clock edge.
- Error flag: faulty model returns 3'd7 for one nibble -> err=1 from the next edge and held through DONE; cleared on the next accept.
